// File: rtl/piso_tx_sched.sv
// +--------------------------------------------------------------------+
// | piso_tx_sched: 4-channel round-robin scheduler feeding an 8-bit     |
// | MSB-first serializer; optional even parity via PISO_TX_PARITY_EN.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module piso_tx_sched #(
  parameter int GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] pi,
  output logic [3:0]  gnt,
  output logic        so,
  output logic        frame,
  output logic        busy,
  output logic [1:0]  ch
);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd3
  } state_t;
`endif

  localparam logic [3:0] c_gap_last = 4'(GAP - 1);

  state_t      r_state, w_state;
  logic [7:0]  r_shift, w_shift;
  logic [3:0]  r_cnt, w_cnt;
  logic [1:0]  r_last, w_last;
  logic [3:0]  w_gnt;
  logic        w_so, w_frame, w_busy;
  logic [1:0]  w_ch;
  logic [1:0]  w_win;
  logic        w_found;
  logic [7:0]  w_byte;
`ifdef PISO_TX_PARITY_EN
  logic        r_par, w_par;
`endif

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && req[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last + 2'(k);
      end
    end
    w_byte = pi[{w_win, 3'b000} +: 8];
  end

  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_gnt   = 4'b0000;
    w_so    = 1'b0;
    w_frame = 1'b0;
    w_ch    = ch;
`ifdef PISO_TX_PARITY_EN
    w_par   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_SHIFT;
          w_shift = w_byte;
          w_so    = w_byte[7];
          w_frame = 1'b1;
          w_gnt   = 4'b0001 << w_win;
          w_ch    = w_win;
          w_last  = w_win;
          w_cnt   = 4'd0;
`ifdef PISO_TX_PARITY_EN
          w_par   = ^w_byte;
`endif
        end
      end
      S_SHIFT: begin
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == 4'd7) begin
          w_cnt = 4'd0;
`ifdef PISO_TX_PARITY_EN
          w_state = S_PARITY;
          w_so    = r_par;
          w_frame = 1'b1;
`else
          w_state = (GAP > 0) ? S_GAP : S_IDLE;
`endif
        end else begin
          w_so    = r_shift[6];
          w_frame = 1'b1;
          w_shift = {r_shift[6:0], 1'b0};
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: begin
        w_cnt   = 4'd0;
        w_state = (GAP > 0) ? S_GAP : S_IDLE;
      end
`endif
      S_GAP: begin
        w_cnt = r_cnt + 4'd1;
        if (r_cnt == c_gap_last) begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= 8'd0;
      r_cnt   <= 4'd0;
      r_last  <= 2'd3;
      gnt     <= 4'b0000;
      so      <= 1'b0;
      frame   <= 1'b0;
      busy    <= 1'b0;
      ch      <= 2'd0;
`ifdef PISO_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      gnt     <= w_gnt;
      so      <= w_so;
      frame   <= w_frame;
      busy    <= w_busy;
      ch      <= w_ch;
`ifdef PISO_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: two instances (GAP=1, GAP=0) against a queue-based frame model.
`default_nettype none

module tb_piso_tx_sched;

  localparam int G0 = 1;
  localparam int G1 = 0;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct packed {
    logic       so;
    logic       frame;
    logic [3:0] gnt;
    logic [1:0] ch;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] pi  = 32'b0;

  logic [1:0]  so_v, frame_v, busy_v;
  logic [3:0]  gnt_v [2];
  logic [1:0]  ch_v  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ent_t       mq [2][$];
  ent_t       m_cur  [2];
  logic [1:0] m_last [2];
  bit         m_busy [2];

  int         gt0[$], gt1[$];
  logic [1:0] gc0[$], gc1[$];
  logic       sb0[$];

  always #5 clk = ~clk;

  piso_tx_sched #(.GAP(G0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .pi(pi),
    .gnt(gnt_v[0]), .so(so_v[0]), .frame(frame_v[0]), .busy(busy_v[0]), .ch(ch_v[0])
  );

  piso_tx_sched #(.GAP(G1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .pi(pi),
    .gnt(gnt_v[1]), .so(so_v[1]), .frame(frame_v[1]), .busy(busy_v[1]), .ch(ch_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_cur[i]  = '0;
      m_last[i] = 2'd3;
      m_busy[i] = 1'b0;
    end
  endtask

  // One frame = a list of output cycles queued at grant time; idle when the list runs dry.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i] && req != 4'b0) begin
        int         wi;
        bit         f;
        logic [7:0] b;
        wi = 0;
        f  = 1'b0;
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (int'(m_last[i]) + 1 + k) % 4;
          if (!f && req[c]) begin
            f  = 1'b1;
            wi = c;
          end
        end
        b = pi[8*wi +: 8];
        for (int j = 7; j >= 0; j--)
          mq[i].push_back('{so: b[j], frame: 1'b1,
                            gnt: (j == 7) ? (4'b0001 << wi) : 4'b0000, ch: 2'(wi)});
`ifdef PISO_TX_PARITY_EN
        mq[i].push_back('{so: ^b, frame: 1'b1, gnt: 4'b0000, ch: 2'(wi)});
`endif
        for (int g = 0; g < ((i == 0) ? G0 : G1); g++)
          mq[i].push_back('{so: 1'b0, frame: 1'b0, gnt: 4'b0000, ch: 2'(wi)});
        m_last[i] = 2'(wi);
      end
      if (mq[i].size() > 0) begin
        m_cur[i]  = mq[i].pop_front();
        m_busy[i] = 1'b1;
      end else begin
        m_cur[i].so    = 1'b0;
        m_cur[i].frame = 1'b0;
        m_cur[i].gnt   = 4'b0000;
        m_busy[i]      = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("so%0d", i),    32'(so_v[i]),    32'(m_cur[i].so));
      chk($sformatf("frame%0d", i), 32'(frame_v[i]), 32'(m_cur[i].frame));
      chk($sformatf("busy%0d", i),  32'(busy_v[i]),  32'(m_busy[i]));
      chk($sformatf("gnt%0d", i),   32'(gnt_v[i]),   32'(m_cur[i].gnt));
      chk($sformatf("ch%0d", i),    32'(ch_v[i]),    32'(m_cur[i].ch));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_all();
      if (gnt_v[0] != 4'b0) begin gt0.push_back(cyc); gc0.push_back(ch_v[0]); end
      if (gnt_v[1] != 4'b0) begin gt1.push_back(cyc); gc1.push_back(ch_v[1]); end
      if (frame_v[0]) sb0.push_back(so_v[0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    run(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    gt0.delete(); gt1.delete(); gc0.delete(); gc1.delete(); sb0.delete();
  endtask

  task automatic check_bits(input string tag, input logic [7:0] b);
    chk({tag, "_len"}, 32'(sb0.size()), 32'(8 + P));
    if (sb0.size() == 8 + P) begin
      for (int j = 0; j < 8; j++)
        chk($sformatf("%s_bit%0d", tag, j), 32'(sb0[j]), 32'(b[7-j]));
`ifdef PISO_TX_PARITY_EN
      chk({tag, "_par"}, 32'(sb0[8]), 32'(^b));
`endif
    end
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();

    // Reset state
    do_reset();
    run(2);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_ch0", 32'(ch_v[0]), 32'd0);

    // Single frame of 0xC6 on channel 0
    clear_logs();
    req = 4'b0001;
    pi  = 32'h000000C6;
    run(1);
    chk("c6_gnt", 32'(gnt_v[0]), 32'h1);
    chk("c6_first", 32'(so_v[0]), 32'd1);
    req = 4'b0000;
    run(14);
    pat = 8'hC6;
    check_bits("c6", pat);
    chk("c6_idle", 32'(busy_v), 32'd0);

    // All four requesting: rotating grants with fixed spacing
    do_reset();
    clear_logs();
    req = 4'b1111;
    pi  = 32'h44332211;
    run(5 * (9 + G0 + P) + 2);
    req = 4'b0000;
    run(15);
    chk("rr_count", 32'(gc0.size() >= 5), 32'd1);
    if (gc0.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_ch%0d", k), 32'(gc0[k]), 32'(k % 4));
      for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), 32'(gt0[k] - gt0[k-1]), 32'(9 + G0 + P));
    end

    // Parity cases (frame length checked in both builds)
    clear_logs();
    req = 4'b0001; pi = 32'h00000007;
    run(1);
    req = 4'b0000;
    run(13);
    pat = 8'h07;
    check_bits("p07", pat);
    clear_logs();
    req = 4'b0001; pi = 32'h0000003F;
    run(1);
    req = 4'b0000;
    run(13);
    pat = 8'h3F;
    check_bits("p3f", pat);

    // Asynchronous reset in the middle of an 0xFF frame
    do_reset();
    req = 4'b0001; pi = 32'h000000FF;
    run(1);
    req = 4'b0000;
    run(3);
    chk("ar_frame_pre", 32'(frame_v[0]), 32'd1);
    chk("ar_so_pre", 32'(so_v[0]), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar_so", 32'(so_v), 32'd0);
    chk("ar_frame", 32'(frame_v), 32'd0);
    chk("ar_busy", 32'(busy_v), 32'd0);
    check_all();
    run(1);
    rst = 1'b0;
    clear_logs();
    req = 4'b1111; pi = 32'h8877AA55;
    run(1);
    chk("ar_next_gnt", 32'(gnt_v[0]), 32'h1);
    req = 4'b0000;
    run(14);

    // Byte change mid-frame on channel 1 must not corrupt the frame
    clear_logs();
    req = 4'b0010; pi = 32'h0000A500;
    run(1);
    req = 4'b0000; pi = 32'h00000000;
    run(13);
    pat = 8'hA5;
    check_bits("a5", pat);

    // GAP=0 instance: back-to-back frames on channel 2
    clear_logs();
    req = 4'b0100; pi = 32'h005A0000;
    run(4 * (9 + G1 + P) + 2);
    req = 4'b0000;
    run(14);
    chk("g0_count", 32'(gt1.size() >= 4), 32'd1);
    if (gt1.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("g0_ch%0d", k), 32'(gc1[k]), 32'd2);
      for (int k = 1; k < 4; k++) chk($sformatf("g0_gap%0d", k), 32'(gt1[k] - gt1[k-1]), 32'(9 + G1 + P));
    end

    // Randomized traffic, including withdrawn requests and byte churn
    for (int r = 0; r < 400; r++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      pi  = $urandom;
      run(1);
    end
    req = 4'b0000;
    run(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_tx_sched.md
PISO_TX_SCHED -- requirements
Module: piso_tx_sched

Interface
REQ-001 SHALL have parameter: GAP, 1, idle cycles (0..15) inserted after each frame before returning to IDLE.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  4  per-channel transmit request, level, held until that channel's gnt.
REQ-005 SHALL have port: pi  input  32  parallel bytes; channel k byte = pi[8k+7:8k], held stable with req[k].
REQ-006 SHALL have port: gnt  output  4  one-hot, one-cycle pulse; byte of that channel captured.
REQ-007 SHALL have port: so  output  1  serial data out, MSB first.
REQ-008 SHALL have port: frame  output  1  high exactly while so carries a data or parity bit.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: ch  output  2  index of channel currently or last transmitted.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY (macro only) and GAP; all outputs registered.
REQ-012 SHALL, in IDLE with req!=0, at the clock edge: select winner, load 8-bit shift register with its byte, set gnt one-hot for one cycle, latch ch, clear bit counter, and enter SHIFT.
REQ-013 SHALL arbitrate round-robin: priority order last+1, last+2, last+3, last (mod 4), where last is the previously granted channel.
REQ-014 SHALL, in SHIFT, drive so = shift[7] and frame=1; shift left one bit per cycle, for exactly 8 cycles.
REQ-015 SHALL, after the 8th data bit, go to PARITY if enabled, else to GAP if GAP>0, else to IDLE.
REQ-016 SHALL, in GAP, drive so=0 and frame=0 for exactly GAP cycles, then go to IDLE.
REQ-017 SHALL, in IDLE, drive so=0, frame=0, busy=0.
REQ-018 SHALL have first data bit on so in the cycle directly after the grant edge; gnt and first bit coincide.
REQ-019 SHALL have grant-to-grant spacing under continuous request of 9+GAP cycles (+1 with parity).
REQ-020 SHALL ignore req and pi changes outside IDLE; a captured byte is always sent in full.
REQ-021 SHALL never assert more than one gnt bit; with req==0 it SHALL remain in IDLE indefinitely.
REQ-022 SHALL treat a requester that drops req before grant as withdrawn (no grant, no frame).

Reset
REQ-023 SHALL, on rst high, immediately (asynchronously) force IDLE, so=0, frame=0, busy=0, gnt=0, ch=0, bit counter=0, shift register=0.
REQ-024 SHALL reset round-robin pointer to 3 so channel 0 has first priority.
REQ-025 SHALL abort any frame in progress on reset; no partial-frame resumption.

Configuration
REQ-026 SHALL, with PISO_TX_PARITY_EN defined, add PARITY state: one cycle after data, so = even parity (XOR of 8 data bits), frame=1.
REQ-027 SHALL, without PISO_TX_PARITY_EN, omit PARITY state and parity logic entirely; frame is 8 cycles.

Verification
REQ-028 SHALL verify: reset, req=4'b0001, pi[7:0]=8'hC6, GAP=1 -> gnt=0001 one cycle, so=1,1,0,0,0,1,1,0 with frame=1 for 8 cycles, then so=0, busy=0.
REQ-029 SHALL verify: req=4'b1111 held with all four bytes distinct -> gnt order ch 0,1,2,3,0, spacing 10 cycles (GAP=1, no parity).
REQ-030 SHALL verify: PISO_TX_PARITY_EN, byte 8'h07 -> 8 data bits then parity bit 1. Byte 8'h3F -> parity bit 0. frame=9 cycles.
REQ-031 SHALL verify: rst asserted asynchronously after 4th data bit of 8'hFF -> so, frame, busy fall to 0 without clock edge; next grant goes to channel 0.
REQ-032 SHALL verify: pi[15:8] changed from 8'hA5 to 8'h00 mid-frame on ch1 -> so still A5 pattern 1,0,1,0,0,1,0,1.
REQ-033 SHALL verify: GAP=0, req=4'b0100 held -> back-to-back frames every 9 cycles, ch=2, one gnt pulse per frame.
